// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared constants for the HI/LO multiply/divide unit: R-type func codes that
// the decoder forwards, FSM state encoding, and a func-code classifier.
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // True for the four func codes that launch an iterative operation.
  function automatic logic fn_is_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// Shared 2*W accumulator for shift-add multiply and restoring divide, plus the
// sign/zero bookkeeping needed to produce final HI/LO values.
//   clk, rst_n     : clock, synchronous active-low reset
//   load_i         : capture operands (magnitudes for signed ops) and op kind
//   step_i         : perform one multiply or divide iteration
//   is_div_i       : operation being loaded is a divide
//   is_signed_i    : operation being loaded is signed (MULT/DIV)
//   a_i, b_i       : rs/rt operand values
//   hi_res_o/lo_res_o : sign-corrected results, valid after W steps
// -----------------------------------------------------------------------------
module muldiv_datapath #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         is_div_i,
  input  logic         is_signed_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] hi_res_o,
  output logic [W-1:0] lo_res_o
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   a_raw_q, a_raw_d;
  logic           div_q, div_d;
  logic           neg_q, neg_d;
  logic           nega_q, nega_d;
  logic           dbz_q, dbz_d;

  logic           sign_a, sign_b;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shr;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   rem, quo;

  always_comb begin
    sign_a = is_signed_i & a_i[W-1];
    sign_b = is_signed_i & b_i[W-1];
    mag_a  = sign_a ? -a_i : a_i;
    mag_b  = sign_b ? -b_i : b_i;

    // Multiply: upper half plus multiplicand keeps its carry, which becomes
    // the MSB after the right shift.
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Divide: remainder/quotient pair shifted left by one; the shifted
    // remainder needs one extra bit before the trial subtraction.
    div_shr  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = div_shr - {1'b0, opb_q};
    div_ge   = (div_shr >= {1'b0, opb_q});

    acc_d   = acc_q;
    opb_d   = opb_q;
    a_raw_d = a_raw_q;
    div_d   = div_q;
    neg_d   = neg_q;
    nega_d  = nega_q;
    dbz_d   = dbz_q;

    if (load_i) begin
      div_d   = is_div_i;
      neg_d   = sign_a ^ sign_b;
      nega_d  = sign_a;
      dbz_d   = (b_i == '0);
      a_raw_d = a_i;
      if (is_div_i) begin
        acc_d = {{W{1'b0}}, mag_a};
        opb_d = mag_b;
      end else begin
        acc_d = {{W{1'b0}}, mag_b};
        opb_d = mag_a;
      end
    end else if (step_i) begin
      if (div_q) begin
        acc_d = div_ge ? {div_diff[W-1:0], acc_q[W-2:0], 1'b1}
                       : {div_shr[W-1:0], acc_q[W-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[W-1:1]};
      end
    end
  end

  // Final sign correction; divide-by-zero bypasses it entirely.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    rem      = acc_q[2*W-1:W];
    quo      = acc_q[W-1:0];
    if (div_q) begin
      hi_res_o = dbz_q ? a_raw_q   : (nega_q ? -rem : rem);
      lo_res_o = dbz_q ? {W{1'b1}} : (neg_q  ? -quo : quo);
    end else begin
      hi_res_o = prod_fix[2*W-1:W];
      lo_res_o = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      opb_q   <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      a_raw_q <= a_raw_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      nega_q  <= nega_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MIPS HI/LO unit: MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, func       : EX holds a mul/div; func selects which
//   rs_val, rt_val    : operands A/B (rs_val is also the MTHI/MTLO source)
//   rd_req, wr_req    : EX holds MFHI/MFLO resp. MTHI/MTLO
//   flush             : squash the in-flight operation
//   stall, busy, done : hazard hold, FSM not idle, commit pulse
//   rd_data           : HI/LO read port selected by func
//   hi, lo            : architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             load, step;
  logic [WIDTH-1:0] hi_res, lo_res;

  muldiv_datapath #(.W(WIDTH)) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .step_i      (step),
    .is_div_i    ((func == FN_DIV) || (func == FN_DIVU)),
    .is_signed_i ((func == FN_MULT) || (func == FN_DIV)),
    .a_i         (rs_val),
    .b_i         (rt_val),
    .hi_res_o    (hi_res),
    .lo_res_o    (lo_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;

    if (flush && (state_q != S_IDLE)) begin
      // Squash: abandon the operation, HI/LO untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // A start, even with a bad func, suppresses a coincident MTHI/MTLO.
            if (fn_is_op(func)) begin
              load    = 1'b1;
              cnt_d   = '0;
              state_d = S_RUN;
            end
          end else if (wr_req) begin
            if (func == FN_MTHI) hi_d = rs_val;
            if (func == FN_MTLO) lo_d = rs_val;
          end
        end
        S_RUN: begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          hi_d    = hi_res;
          lo_d    = lo_res;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign stall   = busy & (start | rd_req | wr_req);
  // The commit happens on the edge closing FIX; a coinciding reset or flush
  // cancels it, so the pulse is suppressed as well.
  assign done    = (state_q == S_FIX) & rst_n & ~flush;
  assign rd_data = (func == FN_MFHI) ? hi_q :
                   (func == FN_MFLO) ? lo_q : '0;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle MIPS HI/LO unit for MULT, MULTU, DIV and DIVU, plus the MFHI, MFLO, MTHI and MTLO accesses to the same registers.
- Multiply is iterative shift-add; divide is iterative restoring, one bit per cycle.
- Sits beside the ALU in EX. The instruction decoder raises `start`/`rd_req`/`wr_req` from the R-type func code.
- Drives `stall` to the hazard unit, which freezes PC, IF/ID and ID/EX while the unit is busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be even and ≥8.
- CNT_W, 5, iteration counter width; equals clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  EX holds a MULT/MULTU/DIV/DIVU.
- func  in  6  R-type func code, qualified by start/rd_req/wr_req.
- rs_val  in  WIDTH  operand A: multiplicand/dividend, or the MTHI/MTLO source.
- rt_val  in  WIDTH  operand B: multiplier/divisor.
- rd_req  in  1  EX holds MFHI/MFLO.
- wr_req  in  1  EX holds MTHI/MTLO.
- flush  in  1  kill the in-flight operation (branch/exception squash).
- stall  out  1  hold pipeline.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse when HI/LO are committed by an op.
- rd_data  out  WIDTH  HI if func=MFHI, LO if func=MFLO, else 0. Combinational from the registers.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; hi=lo=0; counter=0; stall=busy=done=0.
  - Reset mid-operation discards the operation.
- States:
  - IDLE: waits for work.
  - RUN: exactly WIDTH iterations.
  - FIX: sign correction and HI/LO commit.
- IDLE behaviour:
  - start=1 with a valid func: latch |A| and |B| (magnitudes only for MULT/DIV; raw for the U forms), latch op kind and the result signs. Go to RUN, counter=0.
  - Invalid func with start: ignored.
  - wr_req=1: MTHI writes hi←rs_val, MTLO writes lo←rs_val, in the same edge.
  - If start and wr_req are both 1 (illegal decode), start wins.
- RUN:
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2·WIDTH accumulator; then shift right one bit.
  - Divide: shift the remainder/quotient pair left; trial-subtract the divisor; keep the difference and set the quotient bit if it is non-negative.
  - counter increments each cycle. When counter==WIDTH-1, go to FIX.
- FIX:
  - MULT: negate the 2·WIDTH product if sign(A)^sign(B).
  - DIV: negate the quotient if sign(A)^sign(B); the remainder takes the sign of A.
  - Commit: hi←upper/remainder, lo←lower/quotient.
  - done=1 for this cycle; next state is IDLE.
- Latency: start seen at edge N; hi/lo valid after edge N+WIDTH+1 (edge N+33 for WIDTH=32). A back-to-back start is accepted at edge N+WIDTH+2.
- Divide by zero (B==0), both DIV and DIVU:
  - Sign fixup is skipped.
  - lo=all ones, hi=rs_val as originally presented.
  - Latency is unchanged.
- Signed overflow 0x8000_0000 / -1 yields lo=0x8000_0000, hi=0, with no trap.
- stall = busy & (start | rd_req | wr_req).
  - Independent instructions proceed while the unit computes.
  - stall is combinational and deasserts in the cycle after FIX. The held instruction then executes normally.
- rd_data during busy is don't-care; the consumer is stalled.
- flush=1 while busy: return to IDLE at the next edge, hi/lo unchanged, no done pulse. flush in IDLE is a no-op.
- Priority when inputs coincide: rst_n > flush > FSM progress > new start/wr_req.

Decomposition:
- Shared header muldiv_constants.vh, alongside controller_constants.vh:
  - FN_MULT 6'h18, FN_MULTU 6'h19, FN_DIV 6'h1A, FN_DIVU 6'h1B.
  - FN_MFHI 6'h10, FN_MTHI 6'h11, FN_MFLO 6'h12, FN_MTLO 6'h13.
  - State encodings S_IDLE 2'd0, S_RUN 2'd1, S_FIX 2'd2.
- One natural sub-module, muldiv_datapath:
  - Holds the accumulator/shift registers and the add/subtract step.
  - Is driven by op, step and load strobes from the FSM in muldiv_sequencer.

Test Plan:
1. MULTU rs=0xFFFF_FFFF, rt=0xFFFF_FFFF → after 33 cycles hi=0xFFFF_FFFE, lo=0x0000_0001; done pulses once; busy high for 33 cycles.
2. MULT rs=-7 (0xFFFF_FFF9), rt=6 → hi=0xFFFF_FFFF, lo=0xFFFF_FFD6.
3. DIV rs=-7, rt=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU rs=7, rt=0 → lo=0xFFFF_FFFF, hi=0x0000_0007.
4. MULT issued, then MFLO requested 3 cycles later → stall=1 until the cycle after FIX; rd_data equals the new lo once stall drops. An unrelated ADD in between sees stall=0.
5. MTHI rs=0x1234_5678 in IDLE → hi=0x1234_5678 next cycle, no stall. Next, DIV started and flush asserted at RUN cycle 10 → IDLE next edge, hi still 0x1234_5678, no done.
6. rst_n=0 during RUN → next edge state IDLE, hi=lo=0, stall=busy=done=0. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
